anubis_round_engine: RTL and testbench
======================================

# anubis_round_engine

Iterative Anubis encryption core that runs the full cipher on one 128-bit block: initial key addition, then R = 8 + N rounds of γ, τ, θ, σ, with θ omitted in the last round. It replaces single-round use with a self-sequencing engine. It sits between the text input register and the key-schedule block. Round keys are fetched per round over a request/valid handshake. S-box throughput is parametrised in byte lanes, so area and latency can be traded.

## Interface
- N, 4, key length in 32-bit words; legal 4..10; sets R = 8 + N.
- LANES, 16, γ S-box lookups per cycle; legal 1, 2, 4, 8, 16; G = 16 / LANES.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  sampled in IDLE only; latches plain_text.
- plain_text  in  128  input block.
- key_req  out  1  round-key request.
- key_idx  out  5  index of requested round key, 0..R.
- key_valid  in  1  round_key is valid this cycle.
- round_key  in  128  round key K[key_idx].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; cipher_text updated in that cycle.
- cipher_text  out  128  last result; held until the next completion.

## Operation
- **State byte mapping:** a[i][j] = block[127-8*(4i+j) -: 8], with i, j in 0..3.
- **γ:** each byte passes through the team's Anubis involutional S-box.
- **τ:** transpose, so a[i][j] goes to a[j][i].
- **θ:** multiply the state by had(01,02,04,06) over GF(2^8), reduction polynomial 0x11D.
- **σ[K]:** XOR with the round key.
- **Per-round function:** rounds 1..R-1 apply σ∘θ∘τ∘γ; round R applies σ∘τ∘γ.
- **IDLE:**
  - busy=0, key_req=0.
  - When start=1: state_reg ← plain_text, r ← 0, go to KEY0.
- **KEY0:**
  - key_req=1, key_idx=0.
  - When key_valid=1: state_reg ← state_reg ^ round_key, r ← 1, lane counter ← 0, go to GAMMA.
- **GAMMA:**
  - Each cycle, substitute bytes [LANES*c .. LANES*c+LANES-1] (byte 0 is the MSB) into state_reg, then c ← c+1.
  - After G cycles, go to KEYR.
- **KEYR:**
  - key_req=1, key_idx=r.
  - When key_valid=1, state_reg ← σ[round_key](θ?(τ(state_reg))), where θ is applied only if r < R.
  - If r < R: r ← r+1 and go to GAMMA.
  - If r = R: cipher_text ← result, done ← 1, go to IDLE.
- **key_req low:** key_req is low in IDLE and GAMMA. key_idx is 0 whenever key_req=0.
- **Key wait:** key_valid may stay low indefinitely. The engine waits, and state_reg, r and key_idx stay stable.
- **Out-of-state key_valid:** key_valid arriving while key_req=0 is ignored.
- **start while busy:** ignored; plain_text is not re-latched.

## Timing
- **Reset values:** state IDLE; busy=0, key_req=0, key_idx=0, done=0, cipher_text=0; internal state_reg, r and c all cleared.
- **Reset mid-operation:** the operation is aborted asynchronously. No done pulse is produced, and cipher_text returns to 0.
- **Latency** (start sampled at edge 0, key_valid held high): done=1 and the new cipher_text are visible after edge 1 + R*(G+1).
  - N=4, LANES=16: 25 cycles.
  - N=4, LANES=4: 61 cycles.
  - N=10, LANES=16: 37 cycles.
- **Key stalls:** each cycle key_valid is low while key_req=1 adds exactly one cycle.
- **done pulse:** done lasts exactly one cycle, and busy falls in that same cycle.
- **Back-to-back operation:** start may be high in the cycle done=1 is seen. It is accepted on the next edge, giving a gap of zero idle cycles.
- **No path from key_valid:** key_req and key_idx are registered or decoded from state only, with no combinational path from key_valid.

## Test plan
- **Golden vectors, full throughput:** N=4, LANES=16, key_valid tied 1. Run each entry of engine_test_vector.txt (text, K0..K12, expected cipher, from the team C model). Required:
  - cipher_text matches each entry.
  - done arrives 25 cycles after start.
  - key_idx sequence is 0,1,…,12.
- **Lane generalisation:** same vectors with LANES=4 and with LANES=1. Required:
  - identical ciphertexts.
  - latency 61 and 205 cycles respectively.
- **Key stalls:** N=4, LANES=16, key_valid low for 3 cycles at each request. Required:
  - correct ciphertext.
  - latency 25 + 13*3 = 64 cycles.
  - key_idx stable during each stall.
- **Maximum key size:** N=10 vectors. Required:
  - R=18 and key_idx reaches 18.
  - latency 37 cycles (LANES=16).
  - θ absent in round 18 only: result equals the golden value.
- **Reset mid-operation:** reset pulse at cycle 10. Required:
  - all outputs 0 and busy=0 within the reset.
  - no done pulse.
  - the next start produces the correct result.
- **start while busy, then back-to-back:** second start while busy, with a different plain_text. Required:
  - the second start is ignored.
  - the first result is correct.
  - start in the done cycle is accepted with latency 25.

Source files
------------

// File: rtl/anubis_round_engine.sv
// Iterative Anubis encryption engine: initial key addition followed by R = 8 + N rounds,
// fetching one round key per round and substituting LANES state bytes per cycle.
module anubis_round_engine #(
    parameter int N     = 4,
    parameter int LANES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] plain_text,
    output logic         key_req,
    output logic [4:0]   key_idx,
    input  logic         key_valid,
    input  logic [127:0] round_key,
    output logic         busy,
    output logic         done,
    output logic [127:0] cipher_text
);
    localparam int R  = 8 + N;
    localparam int G  = 16 / LANES;
    localparam int CW = (G > 1) ? $clog2(G) : 1;
    localparam logic [4:0]    LAST_ROUND = 5'(R);
    localparam logic [CW-1:0] LAST_LANE  = CW'(G - 1);

    localparam logic [0:255][7:0] SBOX = {
        8'hBA, 8'h54, 8'h2F, 8'h74, 8'h53, 8'hD3, 8'hD2, 8'h4D, 8'h50, 8'hAC, 8'h8D, 8'hBF, 8'h70, 8'h52, 8'h9A, 8'h4C,
        8'hEA, 8'hD5, 8'h97, 8'hD1, 8'h33, 8'h51, 8'h5B, 8'hA6, 8'hDE, 8'h48, 8'hA8, 8'h99, 8'hDB, 8'h32, 8'hB7, 8'hFC,
        8'hE3, 8'h9E, 8'h91, 8'h9B, 8'hE2, 8'hBB, 8'h41, 8'h6E, 8'hA5, 8'hCB, 8'h6B, 8'h95, 8'hA1, 8'hF3, 8'hB1, 8'h02,
        8'hCC, 8'hC4, 8'h1D, 8'h14, 8'hC3, 8'h63, 8'hDA, 8'h5D, 8'h5F, 8'hDC, 8'h7D, 8'hCD, 8'h7F, 8'h5A, 8'h6C, 8'h5C,
        8'hF7, 8'h26, 8'hFF, 8'hED, 8'hE8, 8'h9D, 8'h6F, 8'h8E, 8'h19, 8'hA0, 8'hF0, 8'h89, 8'h0F, 8'h07, 8'hAF, 8'hFB,
        8'h08, 8'h15, 8'h0D, 8'h04, 8'h01, 8'h64, 8'hDF, 8'h76, 8'h79, 8'hDD, 8'h3D, 8'h16, 8'h3F, 8'h37, 8'h6D, 8'h38,
        8'hB9, 8'h73, 8'hE9, 8'h35, 8'h55, 8'h71, 8'h7B, 8'h8C, 8'h72, 8'h88, 8'hF6, 8'h2A, 8'h3E, 8'h5E, 8'h27, 8'h46,
        8'h0C, 8'h65, 8'h68, 8'h61, 8'h03, 8'hC1, 8'h57, 8'hD6, 8'hD9, 8'h58, 8'hD8, 8'h66, 8'hD7, 8'h3A, 8'hC8, 8'h3C,
        8'hFA, 8'h96, 8'hA7, 8'h98, 8'hEC, 8'hB8, 8'hC7, 8'hAE, 8'h69, 8'h4B, 8'hAB, 8'hA9, 8'h67, 8'h0A, 8'h47, 8'hF2,
        8'hB5, 8'h22, 8'hE5, 8'hEE, 8'hBE, 8'h2B, 8'h81, 8'h12, 8'h83, 8'h1B, 8'h0E, 8'h23, 8'hF5, 8'h45, 8'h21, 8'hCE,
        8'h49, 8'h2C, 8'hF9, 8'hE6, 8'hB6, 8'h28, 8'h17, 8'h82, 8'h1A, 8'h8B, 8'hFE, 8'h8A, 8'h09, 8'hC9, 8'h87, 8'h4E,
        8'hE1, 8'h2E, 8'hE4, 8'hE0, 8'hEB, 8'h90, 8'hA4, 8'h1E, 8'h85, 8'h60, 8'h00, 8'h25, 8'hF4, 8'hF1, 8'h94, 8'h0B,
        8'hE7, 8'h75, 8'hEF, 8'h34, 8'h31, 8'hD4, 8'hD0, 8'h86, 8'h7E, 8'hAD, 8'hFD, 8'h29, 8'h30, 8'h3B, 8'h9F, 8'hF8,
        8'hC6, 8'h13, 8'h06, 8'h05, 8'hC5, 8'h11, 8'h77, 8'h7C, 8'h7A, 8'h78, 8'h36, 8'h1C, 8'h39, 8'h59, 8'h18, 8'h56,
        8'hB3, 8'hB0, 8'h24, 8'h20, 8'hB2, 8'h92, 8'hA3, 8'hC0, 8'h44, 8'h62, 8'h10, 8'hB4, 8'h84, 8'h43, 8'h93, 8'hC2,
        8'h4A, 8'hBD, 8'h8F, 8'h2D, 8'hBC, 8'h9C, 8'h6A, 8'h40, 8'hCF, 8'hA2, 8'h80, 8'h4F, 8'h1F, 8'hCA, 8'hAA, 8'h42
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KEY0  = 2'd1,
        ST_GAMMA = 2'd2,
        ST_KEYR  = 2'd3
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int i, input int j);
        return s[127-8*(4*i+j) -: 8];
    endfunction

    function automatic logic [127:0] tau(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                t[127-8*(4*j+i) -: 8] = get_byte(s, i, j);
        return t;
    endfunction

    // Row times had(01,02,04,06): column j takes a[i][j^m] weighted by h[m].
    function automatic logic [127:0] theta(input logic [127:0] s);
        logic [127:0] t;
        logic [7:0]   b2;
        logic [7:0]   b3;
        t = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                b2 = get_byte(s, i, j ^ 2);
                b3 = get_byte(s, i, j ^ 3);
                t[127-8*(4*i+j) -: 8] = get_byte(s, i, j) ^ xtime(get_byte(s, i, j ^ 1))
                                      ^ xtime(xtime(b2)) ^ xtime(xtime(b3)) ^ xtime(b3);
            end
        end
        return t;
    endfunction

    state_e        st_q, st_d;
    logic [127:0]  state_q, state_d;
    logic [4:0]    rnd_q, rnd_d;
    logic [CW-1:0] lane_q, lane_d;
    logic          busy_q, busy_d;
    logic          key_req_q, key_req_d;
    logic [4:0]    key_idx_q, key_idx_d;
    logic          done_q, done_d;
    logic [127:0]  cipher_q, cipher_d;
    logic [127:0]  mixed_s;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        st_d     = st_q;
        state_d  = state_q;
        rnd_d    = rnd_q;
        lane_d   = lane_q;
        done_d   = 1'b0;
        cipher_d = cipher_q;
        mixed_s  = round_key ^ ((rnd_q < LAST_ROUND) ? theta(tau(state_q)) : tau(state_q));
        case (st_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = plain_text;
                    rnd_d   = 5'd0;
                    st_d    = ST_KEY0;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_KEY0: begin
                if (key_valid) begin
                    state_d = state_q ^ round_key;
                    rnd_d   = 5'd1;
                    lane_d  = '0;
                    st_d    = ST_GAMMA;
                end else begin
                    st_d = ST_KEY0;
                end
            end
            ST_GAMMA: begin
                for (int l = 0; l < LANES; l++) begin
                    state_d[127-8*(LANES*int'(lane_q)+l) -: 8] =
                        SBOX[state_q[127-8*(LANES*int'(lane_q)+l) -: 8]];
                end
                if (lane_q == LAST_LANE) begin
                    lane_d = '0;
                    st_d   = ST_KEYR;
                end else begin
                    lane_d = lane_q + CW'(1);
                end
            end
            ST_KEYR: begin
                if (key_valid) begin
                    state_d = mixed_s;
                    if (rnd_q == LAST_ROUND) begin
                        cipher_d = mixed_s;
                        done_d   = 1'b1;
                        st_d     = ST_IDLE;
                    end else begin
                        rnd_d = rnd_q + 5'd1;
                        st_d  = ST_GAMMA;
                    end
                end else begin
                    st_d = ST_KEYR;
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
        busy_d    = (st_d != ST_IDLE);
        key_req_d = (st_d == ST_KEY0) || (st_d == ST_KEYR);
        key_idx_d = (st_d == ST_KEYR) ? rnd_d : 5'd0;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q      <= ST_IDLE;
            state_q   <= 128'd0;
            rnd_q     <= 5'd0;
            lane_q    <= '0;
            busy_q    <= 1'b0;
            key_req_q <= 1'b0;
            key_idx_q <= 5'd0;
            done_q    <= 1'b0;
            cipher_q  <= 128'd0;
        end else begin
            st_q      <= st_d;
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            lane_q    <= lane_d;
            busy_q    <= busy_d;
            key_req_q <= key_req_d;
            key_idx_q <= key_idx_d;
            done_q    <= done_d;
            cipher_q  <= cipher_d;
        end
    end

    assign key_req     = key_req_q;
    assign key_idx     = key_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cipher_text = cipher_q;
endmodule

// File: tb/tb_anubis_round_engine.sv
// Randomised bench for anubis_round_engine: two engines (N=4/LANES=16 and N=10/LANES=4)
// checked every cycle against a transaction-level cipher model.
module tb_anubis_round_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start_s   [2];
    logic [127:0] pt_s      [2];
    logic         kv_s      [2];
    logic [127:0] rk_s      [2];
    logic         key_req_s [2];
    logic [4:0]   key_idx_s [2];
    logic         busy_s    [2];
    logic         done_s    [2];
    logic [127:0] ct_s      [2];

    localparam int RR [2] = '{8 + 4, 8 + 10};
    localparam int GG [2] = '{16 / 16, 16 / 4};

    anubis_round_engine #(.N(4), .LANES(16)) u_eng0 (
        .clk(clk), .reset(rst), .start(start_s[0]), .plain_text(pt_s[0]),
        .key_req(key_req_s[0]), .key_idx(key_idx_s[0]), .key_valid(kv_s[0]),
        .round_key(rk_s[0]), .busy(busy_s[0]), .done(done_s[0]), .cipher_text(ct_s[0]));

    anubis_round_engine #(.N(10), .LANES(4)) u_eng1 (
        .clk(clk), .reset(rst), .start(start_s[1]), .plain_text(pt_s[1]),
        .key_req(key_req_s[1]), .key_idx(key_idx_s[1]), .key_valid(kv_s[1]),
        .round_key(rk_s[1]), .busy(busy_s[1]), .done(done_s[1]), .cipher_text(ct_s[1]));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int kmode   = 0;

    logic [7:0] sb [256] = '{
        8'hBA, 8'h54, 8'h2F, 8'h74, 8'h53, 8'hD3, 8'hD2, 8'h4D, 8'h50, 8'hAC, 8'h8D, 8'hBF, 8'h70, 8'h52, 8'h9A, 8'h4C,
        8'hEA, 8'hD5, 8'h97, 8'hD1, 8'h33, 8'h51, 8'h5B, 8'hA6, 8'hDE, 8'h48, 8'hA8, 8'h99, 8'hDB, 8'h32, 8'hB7, 8'hFC,
        8'hE3, 8'h9E, 8'h91, 8'h9B, 8'hE2, 8'hBB, 8'h41, 8'h6E, 8'hA5, 8'hCB, 8'h6B, 8'h95, 8'hA1, 8'hF3, 8'hB1, 8'h02,
        8'hCC, 8'hC4, 8'h1D, 8'h14, 8'hC3, 8'h63, 8'hDA, 8'h5D, 8'h5F, 8'hDC, 8'h7D, 8'hCD, 8'h7F, 8'h5A, 8'h6C, 8'h5C,
        8'hF7, 8'h26, 8'hFF, 8'hED, 8'hE8, 8'h9D, 8'h6F, 8'h8E, 8'h19, 8'hA0, 8'hF0, 8'h89, 8'h0F, 8'h07, 8'hAF, 8'hFB,
        8'h08, 8'h15, 8'h0D, 8'h04, 8'h01, 8'h64, 8'hDF, 8'h76, 8'h79, 8'hDD, 8'h3D, 8'h16, 8'h3F, 8'h37, 8'h6D, 8'h38,
        8'hB9, 8'h73, 8'hE9, 8'h35, 8'h55, 8'h71, 8'h7B, 8'h8C, 8'h72, 8'h88, 8'hF6, 8'h2A, 8'h3E, 8'h5E, 8'h27, 8'h46,
        8'h0C, 8'h65, 8'h68, 8'h61, 8'h03, 8'hC1, 8'h57, 8'hD6, 8'hD9, 8'h58, 8'hD8, 8'h66, 8'hD7, 8'h3A, 8'hC8, 8'h3C,
        8'hFA, 8'h96, 8'hA7, 8'h98, 8'hEC, 8'hB8, 8'hC7, 8'hAE, 8'h69, 8'h4B, 8'hAB, 8'hA9, 8'h67, 8'h0A, 8'h47, 8'hF2,
        8'hB5, 8'h22, 8'hE5, 8'hEE, 8'hBE, 8'h2B, 8'h81, 8'h12, 8'h83, 8'h1B, 8'h0E, 8'h23, 8'hF5, 8'h45, 8'h21, 8'hCE,
        8'h49, 8'h2C, 8'hF9, 8'hE6, 8'hB6, 8'h28, 8'h17, 8'h82, 8'h1A, 8'h8B, 8'hFE, 8'h8A, 8'h09, 8'hC9, 8'h87, 8'h4E,
        8'hE1, 8'h2E, 8'hE4, 8'hE0, 8'hEB, 8'h90, 8'hA4, 8'h1E, 8'h85, 8'h60, 8'h00, 8'h25, 8'hF4, 8'hF1, 8'h94, 8'h0B,
        8'hE7, 8'h75, 8'hEF, 8'h34, 8'h31, 8'hD4, 8'hD0, 8'h86, 8'h7E, 8'hAD, 8'hFD, 8'h29, 8'h30, 8'h3B, 8'h9F, 8'hF8,
        8'hC6, 8'h13, 8'h06, 8'h05, 8'hC5, 8'h11, 8'h77, 8'h7C, 8'h7A, 8'h78, 8'h36, 8'h1C, 8'h39, 8'h59, 8'h18, 8'h56,
        8'hB3, 8'hB0, 8'h24, 8'h20, 8'hB2, 8'h92, 8'hA3, 8'hC0, 8'h44, 8'h62, 8'h10, 8'hB4, 8'h84, 8'h43, 8'h93, 8'hC2,
        8'h4A, 8'hBD, 8'h8F, 8'h2D, 8'hBC, 8'h9C, 8'h6A, 8'h40, 8'hCF, 8'hA2, 8'h80, 8'h4F, 8'h1F, 8'hCA, 8'hAA, 8'h42
    };

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i, input int j);
        return s[127-8*(4*i+j) -: 8];
    endfunction

    function automatic logic [127:0] b_gamma(input logic [127:0] s);
        logic [127:0] t;
        for (int b = 0; b < 16; b++) t[127-8*b -: 8] = sb[s[127-8*b -: 8]];
        return t;
    endfunction

    function automatic logic [127:0] b_tau(input logic [127:0] s);
        logic [127:0] t;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                t[127-8*(4*i+j) -: 8] = gb(s, j, i);
        return t;
    endfunction

    function automatic logic [127:0] b_theta(input logic [127:0] s);
        logic [7:0]   h [4];
        logic [7:0]   acc;
        logic [127:0] t;
        h = '{8'h01, 8'h02, 8'h04, 8'h06};
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(gb(s, i, k), h[k ^ j]);
                t[127-8*(4*i+j) -: 8] = acc;
            end
        end
        return t;
    endfunction

    // Model state per engine: what the outputs must be, derived from the handshake rules.
    logic         m_busy [2];
    logic         m_req  [2];
    logic         m_done [2];
    logic [4:0]   m_idx  [2];
    int           m_wait [2];
    logic [127:0] m_ct   [2];
    logic [127:0] m_pt   [2];
    logic [127:0] m_keys [2][19];

    function automatic logic [127:0] m_enc(input logic [127:0] pt, input int u, input logic [127:0] klast);
        logic [127:0] s;
        logic [127:0] k;
        s = pt ^ m_keys[u][0];
        for (int r = 1; r <= RR[u]; r++) begin
            k = (r == RR[u]) ? klast : m_keys[u][r];
            s = (r == RR[u]) ? (b_tau(b_gamma(s)) ^ k) : (b_theta(b_tau(b_gamma(s))) ^ k);
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string nm, input int u, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s unit%0d: got %h, expected %h (t=%0t)", nm, u, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                m_busy[u] <= 1'b0; m_req[u] <= 1'b0; m_done[u] <= 1'b0;
                m_idx[u]  <= 5'd0; m_wait[u] <= 0;   m_ct[u]   <= 128'd0;
                m_pt[u]   <= 128'd0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                m_done[u] <= 1'b0;
                if (!m_busy[u]) begin
                    if (start_s[u]) begin
                        m_busy[u] <= 1'b1; m_req[u] <= 1'b1; m_idx[u] <= 5'd0; m_pt[u] <= pt_s[u];
                    end
                end else if (m_req[u]) begin
                    if (kv_s[u]) begin
                        m_keys[u][m_idx[u]] <= rk_s[u];
                        m_req[u] <= 1'b0;
                        if (int'(m_idx[u]) == RR[u]) begin
                            m_busy[u] <= 1'b0;
                            m_done[u] <= 1'b1;
                            m_ct[u]   <= m_enc(m_pt[u], u, rk_s[u]);
                        end else begin
                            m_wait[u] <= GG[u];
                            m_idx[u]  <= m_idx[u] + 5'd1;
                        end
                    end
                end else begin
                    if (m_wait[u] == 1) m_req[u] <= 1'b1;
                    m_wait[u] <= m_wait[u] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            chk("busy", u, 128'(busy_s[u]), 128'(m_busy[u]));
            chk("key_req", u, 128'(key_req_s[u]), 128'(m_req[u]));
            chk("key_idx", u, 128'(key_idx_s[u]), m_req[u] ? 128'(m_idx[u]) : 128'd0);
            chk("done", u, 128'(done_s[u]), 128'(m_done[u]));
            chk("cipher_text", u, ct_s[u], m_ct[u]);
        end
    end

    // Key source: random key data every cycle, key_valid shaped by kmode (0 always, 1 random, 2 three-cycle stall).
    initial begin
        int scnt [2];
        for (int u = 0; u < 2; u++) begin
            scnt[u] = 0; kv_s[u] = 1'b0; rk_s[u] = 128'd0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int u = 0; u < 2; u++) begin
                rk_s[u] = rnd128();
                scnt[u] = key_req_s[u] ? scnt[u] + 1 : 0;
                case (kmode)
                    0:       kv_s[u] = 1'b1;
                    1:       kv_s[u] = 1'($urandom_range(0, 1));
                    default: kv_s[u] = key_req_s[u] ? (scnt[u] > 3) : 1'($urandom_range(0, 1));
                endcase
            end
        end
    end

    task automatic run_op(input int u, input logic [127:0] pt, input int exp_lat, input bit intf);
        int t0;
        int lat;
        bit seen;
        pt_s[u] = pt;
        start_s[u] = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        #1 start_s[u] = 1'b0;
        pt_s[u] = ~pt;
        seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (intf && k == 4) begin
                pt_s[u] = pt ^ 128'h1;
                start_s[u] = 1'b1;
            end else if (intf && k == 5) begin
                start_s[u] = 1'b0;
            end
            if (done_s[u]) seen = 1'b1;
        end
        lat = cyc - t0;
        chk("done_seen", u, 128'(seen), 128'd1);
        if (seen && exp_lat > 0) chk("latency", u, 128'(lat), 128'(exp_lat));
        if (intf) chk("first_result", u, ct_s[u], m_enc(pt, u, m_keys[u][RR[u]]));
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [127:0] x;
        bit seen;
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0; pt_s[u] = 128'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_busy", u, 128'(busy_s[u]), 128'd0);
            chk("rst_key_req", u, 128'(key_req_s[u]), 128'd0);
            chk("rst_cipher", u, ct_s[u], 128'd0);
        end
        #1 rst = 1'b0;

        chk("pin_gmul_80x02", 0, 128'(gmul(8'h80, 8'h02)), 128'h1D);
        chk("pin_gmul_57x06", 0, 128'(gmul(8'h57, 8'h06)), 128'hEF);
        chk("pin_gamma_zero", 0, b_gamma(128'd0), {16{8'hBA}});
        x = rnd128();
        chk("pin_gamma_involution", 0, b_gamma(b_gamma(x)), x);
        chk("pin_tau", 0, b_tau(128'h00AB0000_00000000_00000000_00000000),
            128'h00000000_AB000000_00000000_00000000);
        chk("pin_theta", 0, b_theta(128'h00000000_00000100_00000000_00000000),
            128'h00000000_04060102_00000000_00000000);

        kmode = 0;
        for (int k = 0; k < 3; k++) run_op(0, rnd128(), 25, 1'b0);
        idle(2);
        for (int k = 0; k < 2; k++) run_op(1, rnd128(), 91, 1'b0);
        idle(1);

        kmode = 2;
        run_op(0, rnd128(), 64, 1'b0);
        run_op(0, rnd128(), 64, 1'b0);
        run_op(1, rnd128(), 148, 1'b0);
        idle(2);

        kmode = 1;
        for (int k = 0; k < 6; k++) begin
            run_op(k % 2, rnd128(), 0, 1'b0);
            idle(int'($urandom_range(0, 2)));
        end

        kmode = 0;
        pt_s[0] = rnd128();
        start_s[0] = 1'b1;
        @(posedge clk);
        #2 start_s[0] = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_busy", 0, 128'(busy_s[0]), 128'd0);
        chk("midrst_key_req", 0, 128'(key_req_s[0]), 128'd0);
        chk("midrst_key_idx", 0, 128'(key_idx_s[0]), 128'd0);
        chk("midrst_done", 0, 128'(done_s[0]), 128'd0);
        chk("midrst_cipher", 0, ct_s[0], 128'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1 if (done_s[0]) seen = 1'b1;
        end
        chk("no_done_after_reset", 0, 128'(seen), 128'd0);
        #1;
        run_op(0, rnd128(), 25, 1'b0);
        idle(1);

        run_op(0, rnd128(), 25, 1'b1);
        run_op(0, rnd128(), 25, 1'b0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
